// File: rtl/iiitb_piso_stream_if.sv
// Handshake bundle for the PISO stream serialiser.
// The slave modport is the serialiser; the master modport is the source/sink side.
interface iiitb_piso_stream_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             frame_end;

  modport slave (
    input  in_valid,
    input  in_data,
    input  ser_ready,
    output in_ready,
    output ser_out,
    output ser_valid,
    output frame_start,
    output frame_end
  );

  modport master (
    output in_valid,
    output in_data,
    output ser_ready,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_start,
    input  frame_end
  );
endinterface

// File: rtl/iiitb_piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready on both sides and frame flags.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module iiitb_piso_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  iiitb_piso_stream_if.slave bus
);

  localparam int unsigned IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_e;
`else
  localparam bit HAS_PARITY = 1'b0;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             fe_q, fe_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             transfer;
  logic             last_bit;
  logic             in_ready;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_sreg;
  logic [WIDTH-1:0] shift_sreg;
  logic [IW-1:0]    idx_inc;

  // sreg holds only the bits not yet on ser_out, so the next bit sits at the shift end
  always_comb begin
    first_bit  = 1'b0;
    next_bit   = 1'b0;
    load_sreg  = '0;
    shift_sreg = '0;
    if (LSB_FIRST) begin
      first_bit  = bus.in_data[0];
      load_sreg  = {IDLE_LEVEL, bus.in_data[WIDTH-1:1]};
      next_bit   = sreg_q[0];
      shift_sreg = {IDLE_LEVEL, sreg_q[WIDTH-1:1]};
    end else begin
      first_bit  = bus.in_data[WIDTH-1];
      load_sreg  = {bus.in_data[WIDTH-2:0], IDLE_LEVEL};
      next_bit   = sreg_q[WIDTH-1];
      shift_sreg = {sreg_q[WIDTH-2:0], IDLE_LEVEL};
    end
  end

  assign idx_inc  = idx_q + 1'b1;
  assign transfer = valid_q && bus.ser_ready;

`ifdef PISO_PARITY_EN
  assign last_bit = (state_q == S_PARITY);
`else
  assign last_bit = (state_q == S_DATA) && (idx_q == LAST_IDX);
`endif

  assign in_ready = !wb_rst_i &&
                    ((state_q == S_IDLE) || (transfer && last_bit));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    out_d   = out_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    fe_d    = fe_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = S_DATA;
      idx_d   = '0;
      sreg_d  = load_sreg;
      out_d   = first_bit;
      valid_d = 1'b1;
      fs_d    = 1'b1;
      fe_d    = 1'b0;
`ifdef PISO_PARITY_EN
      par_d   = ^bus.in_data;
`endif
    end else if (transfer && last_bit) begin
      state_d = S_IDLE;
      idx_d   = '0;
      sreg_d  = {WIDTH{IDLE_LEVEL}};
      out_d   = IDLE_LEVEL;
      valid_d = 1'b0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
    end else if (transfer) begin
      idx_d = idx_inc;
      fs_d  = 1'b0;
`ifdef PISO_PARITY_EN
      if (idx_q == LAST_IDX) begin
        state_d = S_PARITY;
        out_d   = par_q;
        fe_d    = 1'b1;
      end else begin
        sreg_d = shift_sreg;
        out_d  = next_bit;
        fe_d   = 1'b0;
      end
`else
      sreg_d = shift_sreg;
      out_d  = next_bit;
      fe_d   = !HAS_PARITY && (idx_inc == LAST_IDX);
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sreg_q  <= {WIDTH{IDLE_LEVEL}};
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ser_out     = out_q;
  assign bus.ser_valid   = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;

endmodule
